sq: RTL and testbench



---
 rtl/sq.sv | 93 +++++++++
 tb/tb_sq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sq.sv
// Sequential unsigned squarer: y = a*a through an iterative shift-and-add datapath,
// one multiplier bit per clock, using the same start/busy handshake as the root unit.
module sq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] y_bo
);

  localparam int unsigned YW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WORK,
    FINISH
  } state_t;

  state_t          state, state_next;
  logic [YW-1:0]   mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [YW-1:0]   acc, acc_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            busy_next;
  logic [YW-1:0]   y_next;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    cnt_next    = cnt;
    busy_next   = busy_o;
    y_next      = y_bo;
    case (state)
      IDLE: begin
        if (start_i) begin
          mcand_next  = YW'(a_i);
          mplier_next = a_i;
          acc_next    = '0;
          cnt_next    = '0;
          y_next      = '0;
          busy_next   = 1'b1;
          state_next  = WORK;
        end
      end
      WORK: begin
        if (mplier[0]) acc_next = acc + mcand;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_next = FINISH;
      end
      FINISH: begin
        y_next     = acc;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      y_bo   <= '0;
    end else begin
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      busy_o <= busy_next;
      y_bo   <= y_next;
    end
  end

endmodule

// File: tb/tb_sq.sv
// Directed bench for sq: reset, latency, extremes, busy-ignore, back-to-back, abort
// and a sweep of small operands, each against hand-computed squares.
module tb_sq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  a_i = '0;
  logic        start_i = 1'b0;
  logic        busy_o;
  logic [15:0] y_bo;

  int n_chk = 0;
  int n_bad = 0;

  sq #(.WIDTH(8)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_i    (a_i),
    .start_i(start_i),
    .busy_o (busy_o),
    .y_bo   (y_bo)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One-cycle start pulse; returns busy length and whether y stayed 0 while busy
  task automatic run_op(input logic [7:0] a, output int cycles, output logic y_zero);
    a_i = a;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    cycles = 0;
    y_zero = 1'b1;
    while (busy_o && cycles < 40) begin
      if (y_bo != 16'd0) y_zero = 1'b0;
      cycles++;
      tick(1);
    end
  endtask

  int   cyc;
  logic yz;

  initial begin
    // Reset held low, then released while idle
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_y", 32'(y_bo), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick(20);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_y", 32'(y_bo), 32'd0);

    // Nominal
    run_op(8'd13, cyc, yz);
    chk("nom_cycles", 32'(cyc), 32'd9);
    chk("nom_y_busy", 32'(yz), 32'd1);
    chk("nom_y", 32'(y_bo), 32'd169);
    tick(3);
    chk("nom_hold", 32'(y_bo), 32'd169);

    // Extremes
    run_op(8'd0, cyc, yz);
    chk("zero_cycles", 32'(cyc), 32'd9);
    chk("zero_y", 32'(y_bo), 32'd0);
    run_op(8'd255, cyc, yz);
    chk("max_cycles", 32'(cyc), 32'd9);
    chk("max_y", 32'(y_bo), 32'd65025);

    // Busy-ignore: extra starts at busy cycles 3 and 9 (FINISH)
    a_i = 8'd10;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(2);
    a_i = 8'd200;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(5);
    chk("ign_busy9", 32'(busy_o), 32'd1);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    chk("ign_done", 32'(busy_o), 32'd0);
    chk("ign_y", 32'(y_bo), 32'd100);
    tick(3);
    chk("ign_no_rerun", 32'(busy_o), 32'd0);
    chk("ign_y_hold", 32'(y_bo), 32'd100);

    // Back-to-back with start held high
    a_i = 8'd7;
    start_i = 1'b1;
    tick(1);
    a_i = 8'd9;
    chk("b2b_busy1", 32'(busy_o), 32'd1);
    tick(8);
    chk("b2b_busy9", 32'(busy_o), 32'd1);
    tick(1);
    chk("b2b_gap_busy", 32'(busy_o), 32'd0);
    chk("b2b_y1", 32'(y_bo), 32'd49);
    tick(1);
    chk("b2b_restart", 32'(busy_o), 32'd1);
    chk("b2b_clear", 32'(y_bo), 32'd0);
    tick(8);
    start_i = 1'b0;
    tick(1);
    chk("b2b_done2", 32'(busy_o), 32'd0);
    chk("b2b_y2", 32'(y_bo), 32'd81);
    tick(2);
    chk("b2b_stop", 32'(busy_o), 32'd0);

    // Abort mid-computation with an asynchronous reset
    a_i = 8'd200;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(3);
    #2;
    rst_i = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_y", 32'(y_bo), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick(12);
    chk("abort_idle_busy", 32'(busy_o), 32'd0);
    chk("abort_no_result", 32'(y_bo), 32'd0);
    run_op(8'd3, cyc, yz);
    chk("post_abort_cycles", 32'(cyc), 32'd9);
    chk("post_abort_y", 32'(y_bo), 32'd9);

    // Small-operand sweep for round-trip use
    for (int a = 0; a < 16; a++) begin
      run_op(8'(a), cyc, yz);
      chk($sformatf("sweep_y_%0d", a), 32'(y_bo), 32'(a * a));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
